// File: rtl/mmult_opt_mdc_pkg.sv
// Shared definitions for the matrix-multiply datapath.
// Holds the MAC actor state encoding and the default operand width and
// vector length used by the actor and by the surrounding FIFO instances.
package mmult_opt_mdc_pkg;

    typedef enum logic {
        S_ACC  = 1'b0,   // consuming A/B pairs
        S_EMIT = 1'b1    // holding a finished dot-product
    } mac_state_e;

    localparam int DEF_SIZE  = 32;
    localparam int DEF_N_LEN = 8;
    localparam int DEF_CNT_W = 6;

endpackage

// File: rtl/mac_unit_mmult_opt_mdc.sv
// Combinational multiply-accumulate element.
// Ports:
//   a, b    : operands (size bits)
//   acc_in  : running sum (size bits)
//   acc_out : acc_in + a*b, modulo 2^size
module mac_unit_mmult_opt_mdc #(
    parameter int size = 32
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic [size-1:0] acc_in,
    output logic [size-1:0] acc_out
);

    logic [size-1:0] prod_lo_s;

    // The low size bits of the full 2*size product are exactly the product
    // evaluated at size bits, so only that slice is built before the add.
    always_comb begin
        prod_lo_s = a * b;
        acc_out   = acc_in + prod_lo_s;
    end

endmodule

// File: rtl/mac_actor_mmult_opt_mdc.sv
// Inner-product actor between two operand FIFOs (A row, B column) and a
// result FIFO. Pops one A/B pair per cycle while both are valid, sums n_len
// products (modulo 2^size) and then holds the result until the result FIFO
// accepts it.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   a_data/a_valid    : head and valid of the A FIFO; a_enr pops it
//   b_data/b_valid    : head and valid of the B FIFO; b_enr pops it
//   out_data/out_enw  : result word and push strobe for the result FIFO
//   out_full          : result FIFO full
module mac_actor_mmult_opt_mdc
    import mmult_opt_mdc_pkg::*;
#(
    parameter int size  = DEF_SIZE,
    parameter int n_len = DEF_N_LEN,
    parameter int cnt_w = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] a_data,
    input  logic            a_valid,
    output logic            a_enr,
    input  logic [size-1:0] b_data,
    input  logic            b_valid,
    output logic            b_enr,
    output logic [size-1:0] out_data,
    output logic            out_enw,
    input  logic            out_full
);

    mac_state_e      state_q, state_d;
    logic [size-1:0] acc_q, acc_d;
    logic [size-1:0] result_q, result_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic [size-1:0] mac_sum_s;
    logic            pop_s;
    logic            enw_s;
    logic            last_s;

    mac_unit_mmult_opt_mdc #(.size(size)) u_mac (
        .a       (a_data),
        .b       (b_data),
        .acc_in  (acc_q),
        .acc_out (mac_sum_s)
    );

    assign last_s = (cnt_q == cnt_w'(n_len - 1));

    // Next-state, accumulator, counter and handshake decode.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        pop_s    = 1'b0;
        enw_s    = 1'b0;
        case (state_q)
            S_ACC: begin
                pop_s = a_valid & b_valid;
                if (pop_s) begin
                    if (last_s) begin
                        result_d = mac_sum_s;
                        acc_d    = {size{1'b0}};
                        cnt_d    = {cnt_w{1'b0}};
                        state_d  = S_EMIT;
                    end else begin
                        acc_d = mac_sum_s;
                        cnt_d = cnt_q + cnt_w'(1);
                    end
                end else begin
                    state_d = S_ACC;
                end
            end
            S_EMIT: begin
                enw_s = ~out_full;
                if (enw_s) begin
                    state_d = S_ACC;
                end else begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_ACC;
            acc_q    <= {size{1'b0}};
            cnt_q    <= {cnt_w{1'b0}};
            result_q <= {size{1'b0}};
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Strobes are gated by rst so no FIFO moves while reset is held,
    // even though the state register already reads S_ACC then.
    assign a_enr    = pop_s & rst;
    assign b_enr    = pop_s & rst;
    assign out_enw  = enw_s & rst;
    assign out_data = result_q;

endmodule

// File: tb/tb_mac_actor_mmult_opt_mdc.sv
module tb_mac_actor_mmult_opt_mdc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_data, b_data, out_data;
    logic        a_valid, b_valid, a_enr, b_enr, out_enw, out_full;

    logic [7:0]  a8_data, b8_data, o8_data;
    logic        a8_valid, b8_valid, a8_enr, b8_enr, o8_enw;

    int tests = 0;
    int fails = 0;
    int e8    = 0;

    logic [31:0] aq[$];
    logic [31:0] bq[$];
    logic [31:0] exp_q[$];
    logic        a_stall, b_stall, w8_en;
    logic        s_aenr, s_enw;
    logic [31:0] s_data;

    logic [31:0] va[4];
    logic [31:0] vb[4];
    logic [31:0] v1[4];

    always #5 clk = ~clk;

    mac_actor_mmult_opt_mdc #(.size(32), .n_len(4), .cnt_w(3)) dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_enr(a_enr),
        .b_data(b_data), .b_valid(b_valid), .b_enr(b_enr),
        .out_data(out_data), .out_enw(out_enw), .out_full(out_full)
    );

    mac_actor_mmult_opt_mdc #(.size(8), .n_len(4), .cnt_w(3)) dut8 (
        .clk(clk), .rst(rst),
        .a_data(a8_data), .a_valid(a8_valid), .a_enr(a8_enr),
        .b_data(b8_data), .b_valid(b8_valid), .b_enr(b8_enr),
        .out_data(o8_data), .out_enw(o8_enw), .out_full(1'b0)
    );

    assign a8_data  = 8'hFF;
    assign b8_data  = 8'hFF;
    assign a8_valid = w8_en;
    assign b8_valid = w8_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        a_valid = (aq.size() > 0) && !a_stall;
        b_valid = (bq.size() > 0) && !b_stall;
        a_data  = (aq.size() > 0) ? aq[0] : 32'd0;
        b_data  = (bq.size() > 0) ? bq[0] : 32'd0;
    endtask

    task automatic push_vec(input logic [31:0] xa[4], input logic [31:0] xb[4], input bit track);
        logic [31:0] e;
        e = 32'd0;
        for (int i = 0; i < 4; i++) begin
            aq.push_back(xa[i]);
            bq.push_back(xb[i]);
            e = e + xa[i] * xb[i];
        end
        if (track) exp_q.push_back(e);
        refresh();
    endtask

    // One clock: sample at negedge, scoreboard/contract checks, then model FIFO pops.
    task automatic cycle();
        logic [31:0] e;
        @(negedge clk);
        s_aenr = a_enr;
        s_enw  = out_enw;
        s_data = out_data;
        chk("enr_pair", {31'd0, b_enr}, {31'd0, a_enr});
        if (a_enr) chk("enr_without_valid", {31'd0, a_valid & b_valid}, 32'd1);
        if (out_enw) begin
            chk("enw_while_full", {31'd0, out_full}, 32'd0);
            chk("sb_has_expect", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_out_data", out_data, e);
            end
        end
        if (o8_enw) begin
            e8++;
            chk("wrap_out8", {24'd0, o8_data}, 32'd4);
        end
        @(posedge clk);
        #1;
        if (s_aenr && aq.size() > 0 && bq.size() > 0) begin
            void'(aq.pop_front());
            void'(bq.pop_front());
        end
        refresh();
    endtask

    initial begin
        va = '{32'd1, 32'd2, 32'd3, 32'd4};
        vb = '{32'd5, 32'd6, 32'd7, 32'd8};
        v1 = '{32'd1, 32'd1, 32'd1, 32'd1};
        rst = 1'b0; a_stall = 1'b0; b_stall = 1'b0; w8_en = 1'b0; out_full = 1'b0;
        a_data = 32'd0; b_data = 32'd0; a_valid = 1'b0; b_valid = 1'b0;

        // Reset: strobes forced low even with valid inputs present.
        repeat (2) @(posedge clk);
        a_valid = 1'b1; b_valid = 1'b1; w8_en = 1'b1;
        @(negedge clk);
        chk("rst_a_enr", {31'd0, a_enr}, 32'd0);
        chk("rst_b_enr", {31'd0, b_enr}, 32'd0);
        chk("rst_out_enw", {31'd0, out_enw}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_a8_enr", {31'd0, a8_enr}, 32'd0);
        a_valid = 1'b0; b_valid = 1'b0; w8_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        refresh();

        // Basic vector: 4 pops, then one output of 70.
        push_vec(va, vb, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("basic_enr", {31'd0, s_aenr}, {31'd0, i < 4});
            chk("basic_enw", {31'd0, s_enw}, {31'd0, i == 4});
        end

        // Starvation: B withheld for 3 cycles mid-vector.
        push_vec(va, vb, 1'b1);
        cycle(); cycle();
        b_stall = 1'b1; refresh();
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("starve_enr", {31'd0, s_aenr}, 32'd0);
            chk("starve_enw", {31'd0, s_enw}, 32'd0);
        end
        b_stall = 1'b0; refresh();
        cycle(); cycle();
        cycle();
        chk("starve_emit", {31'd0, s_enw}, 32'd1);

        // Back-pressure: result FIFO full for 5 cycles in S_EMIT.
        push_vec(va, vb, 1'b1);
        push_vec(va, vb, 1'b1);
        repeat (4) cycle();
        out_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_enw", {31'd0, s_enw}, 32'd0);
            chk("bp_enr", {31'd0, s_aenr}, 32'd0);
            chk("bp_hold_data", s_data, 32'd70);
        end
        out_full = 1'b0;
        cycle();
        chk("bp_release", {31'd0, s_enw}, 32'd1);
        cycle();
        chk("bp_resume", {31'd0, s_aenr}, 32'd1);
        repeat (3) cycle();
        cycle();
        chk("bp_second", {31'd0, s_enw}, 32'd1);

        // Reset mid-vector: partial sum discarded, no output for it.
        push_vec(va, vb, 1'b0);
        cycle(); cycle();
        rst = 1'b0;
        aq.delete(); bq.delete();
        refresh();
        cycle();
        chk("midrst_enw", {31'd0, s_enw}, 32'd0);
        chk("midrst_enr", {31'd0, s_aenr}, 32'd0);
        rst = 1'b1;
        push_vec(v1, v1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("midrst_out_enw", {31'd0, s_enw}, {31'd0, i == 4});
        end
        chk("midrst_out_data", s_data, 32'd4);

        // Streaming 3 vectors; 8-bit instance runs the wrap case alongside.
        w8_en = 1'b1;
        push_vec(va, vb, 1'b1);
        push_vec(va, vb, 1'b1);
        push_vec(va, vb, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cycle();
            chk("stream_enw", {31'd0, s_enw}, {31'd0, (i % 5) == 4});
        end
        w8_en = 1'b0;
        chk("wrap_count", e8, 32'd3);

        // Drain any leftover expectations within a bounded budget.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
